rtp_to_sdi_depacketizer: RTL and testbench

// Receive-side counterpart of the SDI packetizer: parses 32-bit RTP words from the Ethernet

---
 rtl/rtp_to_sdi_depacketizer.sv | 212 +++++++++++++++++++++
 tb/tb_rtp_to_sdi_depacketizer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtp_to_sdi_depacketizer.sv
// RTP receive depacketizer: parses RTP and payload headers from the Ethernet word stream,
// buffers payload words and serializes 10-bit video / 16-bit audio samples toward sdi_tx.
module rtp_to_sdi_depacketizer #(
  parameter int FIFO_DEPTH  = 64,
  parameter int MAX_PAYLOAD = 256,
  parameter int RTP_PT      = 96
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] eth_in,
  input  logic        eth_valid,
  output logic [9:0]  video_data,
  output logic        video_valid,
  input  logic        video_ready,
  output logic [15:0] audio_data,
  output logic        audio_valid,
  input  logic        audio_ready,
  output logic        v_sync,
  output logic        seq_err,
  output logic        hdr_err,
  output logic        overflow,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_HDR, S_TS, S_SSRC, S_PLHDR, S_PAYLOAD, S_DROP} state_t;
  typedef struct packed {
    logic        eof;
    logic        is_audio;
    logic [31:0] data;
  } entry_t;

  state_t      state, state_nxt;
  logic [15:0] rem_q, rem_nxt;
  logic        marker_q, marker_nxt, audio_q, audio_nxt;
  logic        seq_locked;
  logic [15:0] seq_exp;
  logic        hdr_err_nxt, seq_err_nxt, ovf_nxt, pkt_inc, drop_inc, seq_upd, fifo_wr;
  logic        hdr_ok, len_big;

  entry_t        mem [FIFO_DEPTH];
  entry_t        wr_entry;
  logic [AW:0]   wr_ptr, rd_ptr, fifo_cnt;
  logic [AW+1:0] occupancy;
  logic          fifo_empty, store_full, fifo_pop, slot_free;

  entry_t      cur;
  logic        cur_valid;
  logic [1:0]  idx;
  logic        last_sample, advance;

  assign hdr_ok  = (eth_in[31:30] == 2'b10) && (eth_in[22:16] == 7'(RTP_PT));
  assign len_big = eth_in[15:0] > 16'(MAX_PAYLOAD);

  // Storage is counted including the entry held by the serializer, so a stalled
  // sink backs up exactly FIFO_DEPTH payload words before overflow.
  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign occupancy  = {1'b0, fifo_cnt} + {{(AW+1){1'b0}}, cur_valid};
  assign store_full = occupancy >= (AW+2)'(FIFO_DEPTH);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign wr_entry   = '{eof: marker_q && (rem_q == 16'd1), is_audio: audio_q, data: eth_in};

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt   = state;
    rem_nxt     = rem_q;
    marker_nxt  = marker_q;
    audio_nxt   = audio_q;
    hdr_err_nxt = 1'b0;
    seq_err_nxt = 1'b0;
    ovf_nxt     = 1'b0;
    pkt_inc     = 1'b0;
    drop_inc    = 1'b0;
    seq_upd     = 1'b0;
    fifo_wr     = 1'b0;
    if (eth_valid) begin
      case (state)
        S_HDR: begin
          if (!hdr_ok) begin
            hdr_err_nxt = 1'b1;
          end else begin
            seq_upd     = 1'b1;
            seq_err_nxt = seq_locked && (eth_in[15:0] != seq_exp);
            marker_nxt  = eth_in[23];
            state_nxt   = S_TS;
          end
        end
        S_TS:   state_nxt = S_SSRC;
        S_SSRC: state_nxt = S_PLHDR;
        S_PLHDR: begin
          rem_nxt   = eth_in[15:0];
          audio_nxt = eth_in[30];
          if (eth_in[31] || len_big) begin
            hdr_err_nxt = 1'b1;
            drop_inc    = 1'b1;
            state_nxt   = (!len_big && eth_in[15:0] != 16'd0) ? S_DROP : S_HDR;
          end else if (eth_in[15:0] == 16'd0) begin
            pkt_inc   = 1'b1;
            state_nxt = S_HDR;
          end else begin
            state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          rem_nxt = rem_q - 16'd1;
          if (store_full && !slot_free) begin
            ovf_nxt   = 1'b1;
            drop_inc  = 1'b1;
            state_nxt = (rem_q == 16'd1) ? S_HDR : S_DROP;
          end else begin
            fifo_wr = 1'b1;
            if (rem_q == 16'd1) begin
              pkt_inc   = 1'b1;
              state_nxt = S_HDR;
            end
          end
        end
        S_DROP: begin
          rem_nxt = rem_q - 16'd1;
          if (rem_q == 16'd1) state_nxt = S_HDR;
        end
        default: state_nxt = S_HDR;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HDR;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q      <= '0;
      marker_q   <= 1'b0;
      audio_q    <= 1'b0;
      seq_locked <= 1'b0;
      seq_exp    <= '0;
      hdr_err    <= 1'b0;
      seq_err    <= 1'b0;
      overflow   <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      rem_q    <= rem_nxt;
      marker_q <= marker_nxt;
      audio_q  <= audio_nxt;
      hdr_err  <= hdr_err_nxt;
      seq_err  <= seq_err_nxt;
      overflow <= ovf_nxt;
      if (seq_upd) begin
        seq_locked <= 1'b1;
        seq_exp    <= eth_in[15:0] + 16'd1;
      end
      if (pkt_inc)  pkt_count  <= pkt_count + 16'd1;
      if (drop_inc) drop_count <= drop_count + 16'd1;
    end
  end

  // NOTE: the payload RAM has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  // Serializer: the current entry is split into samples; the next entry loads as the last one leaves.
  assign last_sample = cur.is_audio ? (idx == 2'd1) : (idx == 2'd2);
  assign advance     = cur_valid && (cur.is_audio ? audio_ready : video_ready);
  assign slot_free   = advance && last_sample;
  assign fifo_pop    = !fifo_empty && (!cur_valid || slot_free);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cur       <= '0;
      cur_valid <= 1'b0;
      idx       <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        cur       <= mem[rd_ptr[AW-1:0]];
        cur_valid <= 1'b1;
        idx       <= '0;
      end else if (advance) begin
        if (last_sample) cur_valid <= 1'b0;
        else             idx       <= idx + 2'd1;
      end
    end
  end

  always_comb begin
    video_data = '0;
    audio_data = '0;
    if (cur_valid && !cur.is_audio) begin
      case (idx)
        2'd0:    video_data = cur.data[29:20];
        2'd1:    video_data = cur.data[19:10];
        default: video_data = cur.data[9:0];
      endcase
    end
    if (cur_valid && cur.is_audio)
      audio_data = (idx == 2'd0) ? cur.data[31:16] : cur.data[15:0];
  end

  assign video_valid = cur_valid && !cur.is_audio;
  assign audio_valid = cur_valid && cur.is_audio;
  assign v_sync      = cur_valid && cur.eof && last_sample;

endmodule

// File: tb/tb_rtp_to_sdi_depacketizer.sv
// Self-checking bench: directed and randomized RTP packets against a packet-level
// reference model that predicts sample streams, pulses and counters.
module tb_rtp_to_sdi_depacketizer;
  localparam int FIFO_DEPTH  = 64;
  localparam int MAX_PAYLOAD = 256;
  localparam int RTP_PT      = 96;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] eth_in;
  logic        eth_valid;
  logic [9:0]  video_data;
  logic        video_valid, video_ready;
  logic [15:0] audio_data;
  logic        audio_valid, audio_ready;
  logic        v_sync, seq_err, hdr_err, overflow;
  logic [15:0] pkt_count, drop_count;

  always #5 clk = ~clk;

  rtp_to_sdi_depacketizer #(
    .FIFO_DEPTH(FIFO_DEPTH), .MAX_PAYLOAD(MAX_PAYLOAD), .RTP_PT(RTP_PT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .eth_in(eth_in), .eth_valid(eth_valid),
    .video_data(video_data), .video_valid(video_valid), .video_ready(video_ready),
    .audio_data(audio_data), .audio_valid(audio_valid), .audio_ready(audio_ready),
    .v_sync(v_sync), .seq_err(seq_err), .hdr_err(hdr_err), .overflow(overflow),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  typedef struct packed {
    logic        is_audio;
    logic [15:0] data;
    logic        vs;
  } sample_t;

  sample_t     exp_q [$];
  logic [31:0] pl [$];
  int          checks = 0;
  int          errors = 0;
  int          exp_pkt, exp_drop, exp_hdr, exp_seq, exp_ovf;
  int          n_hdr, n_seq, n_ovf;
  bit          m_locked;
  logic [15:0] m_exp;
  bit          cur_m, cur_audio;
  int          cur_len, cur_fit;
  int          rmode = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    exp_q.delete();
    exp_pkt = 0; exp_drop = 0; exp_hdr = 0; exp_seq = 0; exp_ovf = 0;
    n_hdr = 0; n_seq = 0; n_ovf = 0;
    m_locked = 1'b0; m_exp = '0;
  endtask

  function automatic bit model_hdr(input logic [15:0] s, input bit m, input logic [1:0] typ,
                                   input int len, input int fit);
    if (m_locked && s != m_exp) exp_seq++;
    m_exp = s + 16'd1;
    m_locked = 1'b1;
    cur_m = m; cur_audio = typ[0]; cur_len = len; cur_fit = fit;
    if (typ[1] || len > MAX_PAYLOAD) begin
      exp_hdr++; exp_drop++;
      return 1'b0;
    end
    if (len == 0) exp_pkt++;
    return 1'b1;
  endfunction

  function automatic void model_word(input int i, input logic [31:0] w);
    bit eof = cur_m && (i == cur_len - 1);
    if (i < cur_fit) begin
      if (cur_audio) begin
        exp_q.push_back('{is_audio: 1'b1, data: w[31:16], vs: 1'b0});
        exp_q.push_back('{is_audio: 1'b1, data: w[15:0],  vs: eof});
      end else begin
        exp_q.push_back('{is_audio: 1'b0, data: 16'(w[29:20]), vs: 1'b0});
        exp_q.push_back('{is_audio: 1'b0, data: 16'(w[19:10]), vs: 1'b0});
        exp_q.push_back('{is_audio: 1'b0, data: 16'(w[9:0]),   vs: eof});
      end
      if (i == cur_len - 1) exp_pkt++;
    end else if (i == cur_fit) begin
      exp_ovf++; exp_drop++;
    end
  endfunction

  // ---------------- sink ready driver and output monitor ----------------
  initial begin
    video_ready = 1'b0;
    audio_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: begin video_ready = 1'b0; audio_ready = 1'b0; end
        1: begin video_ready = 1'b1; audio_ready = 1'b1; end
        default: begin
          video_ready = 1'($urandom_range(0, 1));
          audio_ready = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  initial begin
    sample_t     s;
    bit          hold_q;
    logic [31:0] hold_val;
    hold_q = 1'b0;
    hold_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_q = 1'b0;
      end else begin
        if (hold_q)
          check("hold_stable", {4'b0, video_valid, audio_valid, video_data, audio_data}, hold_val);
        if (video_valid || audio_valid) check("valid_mutex", video_valid && audio_valid, 0);
        if ((video_valid && video_ready) || (audio_valid && audio_ready)) begin
          check("sample_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            s = exp_q.pop_front();
            check("sample_type", audio_valid, s.is_audio);
            check("sample_data", audio_valid ? audio_data : {6'b0, video_data}, s.data);
            check("v_sync", v_sync, s.vs);
          end
        end
        hold_q   = (video_valid && !video_ready) || (audio_valid && !audio_ready);
        hold_val = {4'b0, video_valid, audio_valid, video_data, audio_data};
        if (hdr_err)  n_hdr++;
        if (seq_err)  n_seq++;
        if (overflow) n_ovf++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input logic [31:0] w, input int gap);
    @(posedge clk); #1;
    eth_in = w;
    eth_valid = 1'b1;
    repeat (gap) begin
      @(posedge clk); #1;
      eth_in = $urandom;
      eth_valid = 1'b0;
    end
  endtask

  task automatic send_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      eth_valid = 1'b0;
    end
  endtask

  task automatic send_hdr(input logic [15:0] s, input bit m, input logic [1:0] typ, input int len,
                          input int fit, input int glo, input int ghi, output bit ok);
    send_word({2'b10, 6'($urandom), m, 7'(RTP_PT), s}, int'($urandom_range(ghi, glo)));
    send_word($urandom, int'($urandom_range(ghi, glo)));
    send_word($urandom, int'($urandom_range(ghi, glo)));
    send_word({typ, 14'($urandom), 16'(len)}, int'($urandom_range(ghi, glo)));
    ok = model_hdr(s, m, typ, len, fit);
  endtask

  task automatic send_pkt(input logic [15:0] s, input bit m, input logic [1:0] typ, input int len,
                          input int fit, input int glo, input int ghi);
    bit ok;
    logic [31:0] w;
    send_hdr(s, m, typ, len, fit, glo, ghi, ok);
    if (len <= MAX_PAYLOAD) begin
      for (int i = 0; i < len; i++) begin
        w = (pl.size() != 0) ? pl.pop_front() : $urandom;
        if (ok) model_word(i, w);
        send_word(w, int'($urandom_range(ghi, glo)));
      end
    end
    send_idle(3);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || video_valid || audio_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_idle"}, video_valid || audio_valid, 0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_pkt_count"}, pkt_count, 16'(exp_pkt));
    check({tag, "_drop_count"}, drop_count, 16'(exp_drop));
    check({tag, "_hdr_err"}, n_hdr, exp_hdr);
    check({tag, "_seq_err"}, n_seq, exp_seq);
    check({tag, "_overflow"}, n_ovf, exp_ovf);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_video_valid"}, video_valid, 0);
    check({tag, "_audio_valid"}, audio_valid, 0);
    check({tag, "_video_data"}, video_data, 0);
    check({tag, "_audio_data"}, audio_data, 0);
    check({tag, "_v_sync"}, v_sync, 0);
    check({tag, "_pulses"}, {seq_err, hdr_err, overflow}, 0);
    check({tag, "_pkt_count"}, pkt_count, 0);
    check({tag, "_drop_count"}, drop_count, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    eth_valid = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    bit          ok;
    logic [15:0] seq;
    logic [31:0] w;
    int          len;
    eth_in = '0;
    eth_valid = 1'b0;
    rst_n = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Video packet, marker set, with first-sample latency probe.
    send_hdr(16'd0, 1'b1, 2'b00, 2, 2, 0, 0, ok);
    model_word(0, 32'h0010_0802);
    send_word(32'h0010_0802, 0);
    @(negedge clk); check("t1_lat_n0", video_valid, 0);
    model_word(1, 32'h3FF0_0000);
    send_word(32'h3FF0_0000, 0);
    @(negedge clk); check("t1_lat_n1", video_valid, 0);
    send_idle(1);
    @(negedge clk); check("t1_lat_n2", video_valid, 1);
    send_idle(2);
    wait_drain("t1");
    check_counts("t1");

    // Audio packet: two samples back-to-back.
    send_hdr(16'd1, 1'b0, 2'b01, 1, 1, 0, 0, ok);
    model_word(0, 32'hABCD_1234);
    send_word(32'hABCD_1234, 0);
    @(negedge clk);
    send_idle(1);
    @(negedge clk);
    @(negedge clk); check("t2_audio_first", audio_valid, 1);
    @(negedge clk); check("t2_audio_second", audio_valid, 1);
    @(negedge clk); check("t2_audio_done", audio_valid, 0);
    wait_drain("t2");
    check_counts("t2");

    // Sequence discontinuity from a fresh tracker.
    do_reset();
    send_pkt(16'd5, 1'b1, 2'b00, 2, 2, 0, 1);
    send_pkt(16'd7, 1'b0, 2'b01, 2, 2, 0, 1);
    wait_drain("t3");
    check_counts("t3");

    // Hunt over a junk word, then header error cases and boundary lengths.
    send_word(32'h0000_0000, 0);
    exp_hdr++;
    send_pkt(16'd8, 1'b1, 2'b01, 2, 2, 0, 0);
    wait_drain("t4");
    check_counts("t4");
    send_pkt(16'd9, 1'b0, 2'b10, 3, 3, 0, 1);
    send_pkt(16'd10, 1'b0, 2'b00, MAX_PAYLOAD + 1, 0, 0, 0);
    send_pkt(16'd11, 1'b1, 2'b00, 0, 0, 0, 0);
    send_pkt(16'd12, 1'b1, 2'b01, MAX_PAYLOAD, MAX_PAYLOAD, 1, 2);
    wait_drain("t4b");
    check_counts("t4b");

    // Overflow with the sink stalled, then drain and resume.
    rmode = 0;
    send_pkt(16'd13, 1'b1, 2'b00, FIFO_DEPTH + 4, FIFO_DEPTH, 0, 0);
    check_counts("t5_stalled");
    rmode = 1;
    wait_drain("t5");
    send_pkt(16'd14, 1'b1, 2'b01, 3, 3, 0, 0);
    wait_drain("t5_next");
    check_counts("t5");

    // Randomized traffic with random sink backpressure and input gaps.
    rmode = 2;
    seq = 16'd15;
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom;
        w[31] = 1'b0;
        send_word(w, 0);
        exp_hdr++;
      end
      if ($urandom_range(0, 4) == 0) seq = seq + 16'($urandom_range(2, 100));
      len = int'($urandom_range(1, 6));
      send_pkt(seq, 1'($urandom_range(0, 1)), {1'b0, 1'($urandom_range(0, 1))}, len, len, 0, 2);
      seq = seq + 16'd1;
      wait_drain("rand");
      check_counts("rand");
    end

    // Asynchronous reset in the middle of a payload.
    rmode = 0;
    send_hdr(seq, 1'b1, 2'b00, 10, 10, 0, 0, ok);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      model_word(i, w);
      send_word(w, 0);
    end
    @(posedge clk); #2;
    check("t6_pre_reset_valid", video_valid, 1);
    #1 rst_n = 1'b0;
    eth_valid = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    model_clear();
    rmode = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_pkt(16'($urandom), 1'b1, 2'b00, 3, 3, 0, 0);
    wait_drain("t6");
    check_counts("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
